// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory responder.
// Size encodings, FSM state codes and address alignment.
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_BUSY    = 2'd1;
  localparam state_t ST_DONE    = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Low two address bits after alignment; reserved size acts as word.
  function automatic logic [1:0] align_low(
    input logic [1:0] lo,
    input logic [1:0] sz
  );
    if (sz == SIZE_BYTE)
      return lo;
    else if (sz == SIZE_HALF)
      return {lo[1], 1'b0};
    else
      return 2'b00;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] lo,
    input logic [1:0] sz
  );
    return lo != align_low(lo, sz);
  endfunction

endpackage

// File: rtl/data_memory_responder_steer.sv
// Big-endian lane steering: read extraction with extension,
// write byte enables. Lane 0 is the byte at the aligned base.
module mem_lane_steer
  import data_memory_pkg::*;
(
  input  logic [1:0]      size,
  input  logic            se,
  input  logic [3:0][7:0] rbytes,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [3:0]      be,
  output logic [3:0][7:0] wbytes
);

  logic sb;

  always_comb begin
    sb     = se & rbytes[0][7];
    rdata  = '0;
    be     = '0;
    wbytes = '0;
    unique case (1'b1)
      size == SIZE_BYTE: begin
        rdata     = {{24{sb}}, rbytes[0]};
        be        = 4'b0001;
        wbytes[0] = wdata[7:0];
      end
      size == SIZE_HALF: begin
        rdata     = {{16{sb}}, rbytes[0], rbytes[1]};
        be        = 4'b0011;
        wbytes[0] = wdata[15:8];
        wbytes[1] = wdata[7:0];
      end
      default: begin
        rdata     = {rbytes[0], rbytes[1],
                     rbytes[2], rbytes[3]};
        be        = 4'b1111;
        wbytes[0] = wdata[31:24];
        wbytes[1] = wdata[23:16];
        wbytes[2] = wdata[15:8];
        wbytes[3] = wdata[7:0];
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// MOV/MOC memory responder with programmable wait, big-endian RAM.
// Define DMR_ALIGN_CHECK_EN to flag misaligned accesses on AddrErr.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH  = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MOV,
  input  logic        RW,
  input  logic [1:0]  Size,
  input  logic        SE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
`ifdef DMR_ALIGN_CHECK_EN
  output logic        AddrErr,
`endif
  output logic        MOC
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  logic [7:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  addr_t       addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [1:0]  size_q, size_d;
  logic        se_q, se_d;
  logic [31:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic        moc_q, moc_d;
  logic        err_q, err_d;

  addr_t           acc_addr;
  addr_t           base;
  addr_t           idx [4];
  logic            acc_rw, acc_se, acc_err;
  logic [1:0]      acc_size;
  logic [31:0]     acc_din;
  logic            go_done, we;
  logic [3:0][7:0] rbytes, wbytes;
  logic [31:0]     rdata;
  logic [3:0]      be;
  logic            unused_addr_hi;

  assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

  // In IDLE the live inputs are the request, so a zero wait works.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_addr = Address[ADDR_WIDTH-1:0];
      acc_rw   = RW;
      acc_size = Size;
      acc_se   = SE;
      acc_din  = DataIn;
    end else begin
      acc_addr = addr_q;
      acc_rw   = rw_q;
      acc_size = size_q;
      acc_se   = se_q;
      acc_din  = din_q;
    end
    base = {acc_addr[ADDR_WIDTH-1:2],
            align_low(acc_addr[1:0], acc_size)};
    for (int i = 0; i < 4; i++) begin
      idx[i]    = base + addr_t'(i);
      rbytes[i] = mem[idx[i]];
    end
`ifdef DMR_ALIGN_CHECK_EN
    acc_err = misaligned(acc_addr[1:0], acc_size);
`else
    acc_err = 1'b0;
`endif
  end

  mem_lane_steer u_steer (
    .size   (acc_size),
    .se     (acc_se),
    .rbytes (rbytes),
    .wdata  (acc_din),
    .rdata  (rdata),
    .be     (be),
    .wbytes (wbytes)
  );

  always_comb begin
    go_done = 1'b0;
    if (state_q == ST_IDLE)
      go_done = MOV && (WAIT_CYCLES == 0);
    else if (state_q == ST_BUSY)
      go_done = (cnt_q == 4'd1);
  end

  assign we = go_done && !acc_rw && !acc_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    size_d  = size_q;
    se_d    = se_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MOV) begin
          addr_d  = Address[ADDR_WIDTH-1:0];
          rw_d    = RW;
          size_d  = Size;
          se_d    = SE;
          din_d   = DataIn;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!MOV) begin
          state_d = ST_RELEASE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (go_done) begin
      moc_d = 1'b1;
      err_d = acc_err;
      if (acc_err)
        dout_d = '0;
      else if (acc_rw)
        dout_d = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      se_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      se_q    <= se_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we && be[i])
        mem[idx[i]] <= wbytes[i];
  end

  assign DataOut = dout_q;
  assign MOC     = moc_q;
`ifdef DMR_ALIGN_CHECK_EN
  assign AddrErr = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (WAIT_CYCLES=2).
// Optional AddrErr checks follow DMR_ALIGN_CHECK_EN.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MOV = 1'b0;
  logic        RW = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        SE = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] DataIn = '0;
  logic [31:0] DataOut;
  logic        MOC;
`ifdef DMR_ALIGN_CHECK_EN
  logic        AddrErr;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] last_read = '0;
  logic        moc_prev = 1'b0;

  always #5 clk = ~clk;

  data_memory_responder #(
    .ADDR_WIDTH  (9),
    .WAIT_CYCLES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .MOV     (MOV),
    .RW      (RW),
    .Size    (Size),
    .SE      (SE),
    .Address (Address),
    .DataIn  (DataIn),
    .DataOut (DataOut),
`ifdef DMR_ALIGN_CHECK_EN
    .AddrErr (AddrErr),
`endif
    .MOC     (MOC)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each MOC rising edge pop and compare.
  always @(negedge clk) begin
    if (MOC && !moc_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_moc: got MOC=1 expected none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mon_dataout", DataOut, e.data);
`ifdef DMR_ALIGN_CHECK_EN
        chk("mon_addrerr", {31'b0, AddrErr}, {31'b0, e.err});
`endif
      end
    end
    moc_prev <= MOC;
  end

  task automatic do_op(input logic rw, input logic [1:0] sz,
                       input logic se, input logic [31:0] addr,
                       input logic [31:0] din,
                       input logic [31:0] rd_exp,
                       input logic exp_err, input int lat,
                       input int hold, input logic quick);
    exp_t e;
    int n;
    if (!quick) @(negedge clk);
    else @(negedge clk);
    e.err  = exp_err;
    e.data = exp_err ? 32'h0 : (rw ? rd_exp : last_read);
    last_read = e.data;
    sb_q.push_back(e);
    MOV = 1'b1; RW = rw; Size = sz; SE = se;
    Address = addr; DataIn = din;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!MOC && n < 20);
    chk("latency", n, lat);
    if (!MOC) begin
      $display("FAIL moc_timeout: got MOC=0 expected 1");
      errors++;
      void'(sb_q.pop_front());
    end
    Address = 32'h0; DataIn = 32'hFFFF_FFFF; RW = ~rw;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_moc", {31'b0, MOC}, 32'd1);
      chk("hold_data", DataOut, e.data);
    end
    @(negedge clk);
    MOV = 1'b0;
    @(posedge clk); #1;
    chk("moc_drop", {31'b0, MOC}, 32'd0);
  endtask

  task automatic rd(input logic [1:0] sz, input logic se,
                    input logic [31:0] a,
                    input logic [31:0] x);
    do_op(1'b1, sz, se, a, 32'h0, x, 1'b0, 3, 0, 1'b0);
    @(posedge clk);
  endtask

  task automatic wr(input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    do_op(1'b0, sz, 1'b0, a, d, 32'h0, 1'b0, 3, 0, 1'b0);
    @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_moc", {31'b0, MOC}, 32'd0);
    chk("reset_dataout", DataOut, 32'h0);
    reset = 1'b0;

    wr(2'b10, 32'h10, 32'hDEADBEEF);
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 0, 32'hDEADBEEF,
          1'b0, 3, 5, 1'b0);
    @(posedge clk);
    rd(2'b00, 1'b0, 32'h10, 32'h0000_00DE);
    rd(2'b00, 1'b0, 32'h11, 32'h0000_00AD);
    rd(2'b00, 1'b0, 32'h12, 32'h0000_00BE);
    rd(2'b00, 1'b0, 32'h13, 32'h0000_00EF);
    rd(2'b00, 1'b1, 32'h12, 32'hFFFF_FFBE);
    rd(2'b01, 1'b1, 32'h10, 32'hFFFF_DEAD);
    rd(2'b01, 1'b0, 32'h12, 32'h0000_BEEF);

    // Release then immediate re-request: one extra edge.
    do_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h55, 0,
          1'b0, 3, 0, 1'b0);
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 0, 32'hDE55BEEF,
          1'b0, 4, 0, 1'b1);
    @(posedge clk);
    rd(2'b10, 1'b0, 32'h0000_0210, 32'hDE55BEEF);
    rd(2'b11, 1'b0, 32'h10, 32'hDE55BEEF);

    wr(2'b10, 32'h20, 32'hCAFEF00D);
    wr(2'b01, 32'h22, 32'h0000_A5A5);
    rd(2'b10, 1'b0, 32'h20, 32'hCAFEA5A5);

    // Reset while BUSY aborts the write.
    @(negedge clk);
    MOV = 1'b1; RW = 1'b0; Size = 2'b10;
    Address = 32'h20; DataIn = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_moc", {31'b0, MOC}, 32'd0);
    chk("abort_dataout", DataOut, 32'h0);
    @(negedge clk);
    reset = 1'b0; MOV = 1'b0;
    last_read = 32'h0;
    repeat (3) @(posedge clk); #1;
    chk("abort_idle_moc", {31'b0, MOC}, 32'd0);
    rd(2'b10, 1'b0, 32'h20, 32'hCAFEA5A5);

`ifdef DMR_ALIGN_CHECK_EN
    do_op(1'b1, 2'b10, 1'b0, 32'h13, 0, 32'h0,
          1'b1, 3, 1, 1'b0);
    @(posedge clk);
    do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h11111111, 0,
          1'b1, 3, 0, 1'b0);
    @(posedge clk);
    do_op(1'b0, 2'b01, 1'b0, 32'h11, 32'h2222, 0,
          1'b1, 3, 0, 1'b0);
    @(posedge clk);
    rd(2'b10, 1'b0, 32'h10, 32'hDE55BEEF);
`else
    rd(2'b10, 1'b0, 32'h13, 32'hDE55BEEF);
    rd(2'b01, 1'b0, 32'h13, 32'h0000_BEEF);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the control unit's memory handshake: samples MOV/RW from the microsequencer, performs a big-endian byte-addressed RAM access after a programmable wait, and answers with MOC.
- Sits between the datapath (MAR/MDR) and the memory array.
- Drives the MOC input that the control unit's condition mux tests in wait states.

Parameters:
- ADDR_WIDTH, 9, number of byte-address bits; the array holds 2**ADDR_WIDTH bytes.
- WAIT_CYCLES, 2, number of BUSY cycles between request capture and MOC assertion. Legal range is 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- MOV  input  1  memory operation valid. Held high by the initiator until it sees MOC.
- RW  input  1  1 = read, 0 = write.
- Size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- SE  input  1  sign-extend read data when 1, zero-extend when 0. Applies only to byte and halfword reads.
- Address  input  32  byte address. Only bits [ADDR_WIDTH-1:0] are used.
- DataIn  input  32  write data, right-justified.
- DataOut  output  32  read data, right-justified and extended.
- MOC  output  1  memory operation complete.

Behaviour:
- Reset values: MOC=0, DataOut=0, state=IDLE, wait counter=0.
  - The array is not cleared by reset.
  - A reset mid-transaction aborts it. A write that has not reached DONE is not committed.
- FSM states: IDLE, BUSY, DONE, RELEASE.
- IDLE:
  - When MOV=1, latch Address, RW, Size, SE and DataIn; load counter=WAIT_CYCLES.
  - Go to BUSY, or directly to DONE if WAIT_CYCLES=0.
- BUSY:
  - Decrement the counter each cycle; go to DONE when the counter reaches 1.
  - Input changes, including MOV dropping, are ignored.
- Entering DONE (a single edge):
  - A write commits its bytes to the array.
  - A read loads DataOut.
  - MOC=1 from that edge onward.
- DONE: MOC and DataOut are held while MOV=1. When MOV=0, go to RELEASE with MOC=0.
- RELEASE: lasts one cycle, then IDLE. MOV is not sampled in RELEASE, so back-to-back requests have a minimum one-cycle gap.
- Latency: the MOV capture edge to MOC=1 takes WAIT_CYCLES+1 edges.
- DataOut holds its last read value until the next read completes. Writes do not change DataOut.
- Big-endian byte lanes, where A is the aligned base:
  - Word: byte[A] goes to [31:24], through byte[A+3] to [7:0].
  - Halfword: byte[A] goes to [15:8], byte[A+1] to [7:0].
  - Byte: byte[A] goes to [7:0].
- Writes take DataIn[7:0], DataIn[15:0] or DataIn[31:0] and modify only the addressed bytes.
- Address bits at and above ADDR_WIDTH are ignored, so addresses wrap modulo 2**ADDR_WIDTH. A word at the top address does not straddle the wrap, because addresses are aligned first (see below).
- Misalignment without the optional feature: low address bits are forced to zero (halfword clears bit 0, word clears bits 1:0).

Optional Feature:
- Macro: DMR_ALIGN_CHECK_EN.
- When defined:
  - Adds output port AddrErr (1 bit, reset 0).
  - A misaligned halfword or word completes the normal handshake with MOC, AddrErr=1 and DataOut=0, and no write occurs.
  - AddrErr follows MOC timing and clears in RELEASE.
- When undefined: there is no AddrErr port, and low-bit forcing applies as described above.

Decomposition:
- Package data_memory_pkg holds:
  - Size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD.
  - The FSM state typedef.
  - A function computing the aligned address.
- One combinational sub-module, mem_lane_steer, does read extraction with sign/zero extension and write byte-enable generation. The FSM and array stay in the top.

Test Plan:
- Write then read with WAIT_CYCLES=2:
  - Word write of 0xDEADBEEF to address 0x10, MOV held. MOC rises on the 3rd edge after capture.
  - Word read of 0x10 returns DataOut=0xDEADBEEF.
  - Byte reads of 0x10..0x13 return 0xDE, 0xAD, 0xBE, 0xEF (SE=0).
- Extension:
  - Byte read of 0x12 with SE=1 returns 0xFFFFFFBE; with SE=0 it returns 0x000000BE.
  - Halfword read of 0x10 with SE=1 returns 0xFFFFDEAD.
- Partial write: byte write of 0x55 to 0x11, then word read of 0x10 returns 0xDE55BEEF.
- Handshake:
  - MOV held 5 cycles after MOC: MOC stays 1 and DataOut is stable.
  - MOV drops: MOC=0 on the next edge.
  - MOV reasserted immediately: accepted one cycle after RELEASE.
- Reset mid-op:
  - Word write of 0x12345678 to 0x20 with reset asserted in BUSY gives MOC=0 and IDLE.
  - A later read of 0x20 returns the prior contents.
- Misaligned word read of 0x13:
  - Without the macro: data from 0x10.
  - With DMR_ALIGN_CHECK_EN: AddrErr=1, DataOut=0, and a word write to 0x13 leaves memory unchanged.
